// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Multi-cycle instruction-fetch sequencer. Owns the program
//               counter, issues one request at a time to instruction memory,
//               latches the returned word and hands it to the execute stage
//               over a valid/ready handshake. Supports branch redirect and
//               halt/resume.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC         PC value loaded on reset
//   PC_STEP          PC increment per accepted instruction (bytes)
// Ports
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   o_mem_req        fetch request to instruction memory
//   o_mem_addr       fetch address (current PC)
//   i_mem_ready      memory returns i_mem_rdata for o_mem_addr this cycle
//   i_mem_rdata      instruction word from memory
//   o_instr_valid    instruction and decoded fields valid for execute
//   i_instr_ready    execute stage accepts the instruction this cycle
//   o_instruction    latched instruction register
//   o_instr_pc       PC the latched instruction was fetched from
//   o_opcode..o_func7 decoded slices of o_instruction
//   i_redirect_valid taken branch/jump: restart fetch at i_redirect_pc
//   i_redirect_pc    redirect target, bits [1:0] ignored
//   i_halt           stop fetching once the current instruction is accepted
//   o_halted         controller is halted
//   o_fetch_count    number of accepted instructions (wraps)
// ============================================================================
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instr_pc,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_func3,
  output logic [6:0]  o_func7,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted,
  output logic [15:0] o_fetch_count
);

  localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic        r_instr_valid;
  logic [31:0] r_instruction;
  logic [31:0] r_instr_pc;
  logic        r_halted;
  logic [15:0] r_fetch_count;

  logic [31:0] w_redirect_pc;
  logic        w_accept;

  assign w_redirect_pc = i_redirect_pc & c_WORD_MASK;
  // Only meaningful in S_VALID, where r_instr_valid is set.
  assign w_accept      = r_instr_valid & i_instr_ready;

  // --------------------------------------------------------------------------
  // Sequencer. Every output is a register updated alongside the state so
  // that no handshake input reaches o_mem_req/o_instr_valid combinationally.
  // A redirect overrides whatever the current state would have done: any
  // coincident memory data or execute-stage acceptance is simply ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instruction <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_halted      <= 1'b0;
      r_fetch_count <= 16'h0000;
    end else if (i_redirect_valid) begin
      r_state       <= S_FETCH;
      r_pc          <= w_redirect_pc;
      r_mem_req     <= 1'b1;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end
        end

        S_FETCH: begin
          // Request and address stay put until memory responds.
          if (i_mem_ready) begin
            r_instruction <= i_mem_rdata;
            r_instr_pc    <= r_pc;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end
        end

        S_VALID: begin
          if (w_accept) begin
            r_fetch_count <= r_fetch_count + 16'd1;
            r_pc          <= r_pc + PC_STEP;
            r_instr_valid <= 1'b0;
            if (i_halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_mem_req <= 1'b1;
            end
          end
        end

        S_HALTED: begin
          // Only a redirect (handled above) or reset leaves this state.
          r_state <= S_HALTED;
        end

        default: begin
          r_state       <= S_IDLE;
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_instruction = r_instruction;
  assign o_instr_pc    = r_instr_pc;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_fetch_count;

  // Decoded fields are plain slices of the instruction register.
  assign o_opcode = r_instruction[6:0];
  assign o_rd     = r_instruction[11:7];
  assign o_func3  = r_instruction[14:12];
  assign o_rs1    = r_instruction[19:15];
  assign o_rs2    = r_instruction[24:20];
  assign o_func7  = r_instruction[31:25];

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench for fetch_controller. A reference model
//               tracks the expected PC and accepted count; fetched words are
//               queued at the memory handshake and compared when accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [15:0] fetch_count;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;
  sb_t sb[$];

  logic [31:0] exp_pc;
  logic [15:0] exp_count;
  logic        use_override;
  logic [31:0] override_word;

  fetch_controller #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ready      (mem_ready),
    .i_mem_rdata      (mem_rdata),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instruction    (instruction),
    .o_instr_pc       (instr_pc),
    .o_opcode         (opcode),
    .o_rd             (rd),
    .o_rs1            (rs1),
    .o_rs2            (rs2),
    .o_func3          (func3),
    .o_func7          (func7),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt           (halt),
    .o_halted         (halted),
    .o_fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word encodes its own address above an ADDI opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign mem_rdata = use_override ? override_word : mem_word(mem_addr);

  // Advance one cycle. At the falling edge, predict the outcome of the next
  // rising edge: queue a fetched word, or pop and compare an accepted one.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (mem_req) begin
      tests_run++;
      if (mem_addr !== exp_pc) begin
        tests_failed++;
        $display("FAIL sb_mem_addr: got %h expected %h", mem_addr, exp_pc);
      end
    end
    if (redirect_valid) begin
      sb.delete();
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (mem_req && mem_ready)
        sb.push_back({exp_pc, use_override ? override_word : mem_word(exp_pc)});
      if (instr_valid && instr_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_underflow: got accepted instr %h expected none", instruction);
        end else begin
          e = sb.pop_front();
          if (instruction !== e.word || instr_pc !== e.pc) begin
            tests_failed++;
            $display("FAIL sb_instr: got %h@%h expected %h@%h", instruction, instr_pc, e.word, e.pc);
          end
        end
        exp_count = exp_count + 16'd1;
        exp_pc    = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_ready      = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    use_override   = 1'b0;
    override_word  = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_pc    = 32'h0;
    exp_count = 16'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({mem_req, instr_valid, halted} !== 3'b000 || mem_addr !== 32'h0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0 || fetch_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got req=%b val=%b hlt=%b addr=%h ins=%h ipc=%h cnt=%h expected all zero",
               mem_req, instr_valid, halted, mem_addr, instruction, instr_pc, fetch_count);
    end
    rst = 1'b0;
    sb.delete();
    exp_pc    = 32'h0;
    exp_count = 16'h0;
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_cycle0: got mem_req=%b expected 0", mem_req);
    end
    tick();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL fetch_cycle1: got req=%b addr=%h expected 1/00000000", mem_req, mem_addr);
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (instr_valid !== ((i % 2) == 1)) begin
        tests_failed++;
        $display("FAIL straight_valid[%0d]: got %b expected %b", i, instr_valid, ((i % 2) == 1));
      end
      tick();
    end
    tests_run++;
    if (fetch_count !== 16'd4 || exp_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL straight_count: got %0d expected 4", fetch_count);
    end
  endtask

  task automatic test_wait_backpressure();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_hold[%0d]: got req=%b addr=%h val=%b expected 1/00000000/0", i, mem_req, mem_addr, instr_valid);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instruction !== 32'h13 || instr_pc !== 32'h0 || mem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got val=%b ins=%h ipc=%h req=%b expected 1/00000013/00000000/0",
                 i, instr_valid, instruction, instr_pc, mem_req);
      end
      if (i < 2) tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4 || fetch_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL stall_advance: got req=%b addr=%h cnt=%0d expected 1/00000004/1", mem_req, mem_addr, fetch_count);
    end
    tick();
    tests_run++;
    if (mem_addr !== 32'h4) begin
      tests_failed++;
      $display("FAIL pc_once: got %h expected 00000004", mem_addr);
    end
  endtask

  task automatic test_decode();
    do_reset();
    use_override  = 1'b1;
    override_word = 32'h40B5_0533;
    mem_ready     = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if (opcode !== 7'b0110011 || rd !== 5'd10 || rs1 !== 5'd10 || rs2 !== 5'd11 ||
        func3 !== 3'd0 || func7 !== 7'b0100000) begin
      tests_failed++;
      $display("FAIL decode: got op=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%b expected 0110011/10/10/11/0/0100000",
               opcode, rd, rs1, rs2, func3, func7);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready  = 1'b0;
    use_override = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    mem_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    mem_ready      = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0 ||
        instruction !== 32'h0 || fetch_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL redirect_fetch: got req=%b addr=%h val=%b ins=%h cnt=%0d expected 1/00000100/0/00000000/0",
               mem_req, mem_addr, instr_valid, instruction, fetch_count);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready      = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (fetch_count !== 16'd0 || instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL redirect_valid_drop: got cnt=%0d val=%b req=%b addr=%h expected 0/0/1/00000200",
               fetch_count, instr_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_halt_resume();
    do_reset();
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL halted[%0d]: got hlt=%b req=%b val=%b expected 1/0/0", i, halted, mem_req, instr_valid);
      end
      tick();
    end
    tests_run++;
    if (fetch_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL halt_count: got %0d expected 1", fetch_count);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL resume: got hlt=%b req=%b addr=%h expected 0/1/00000040", halted, mem_req, mem_addr);
    end
    // Redirect coincident with halt and an accept: redirect wins.
    tick();
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h80 || fetch_count !== exp_count) begin
      tests_failed++;
      $display("FAIL halt_vs_redirect: got hlt=%b req=%b addr=%h cnt=%0d expected 0/1/00000080/%0d",
               halted, mem_req, mem_addr, fetch_count, exp_count);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    mem_ready      = 1'b1;
    instr_ready    = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if (mem_addr !== 32'h0 || fetch_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL pc_wrap: got addr=%h cnt=%0d expected 00000000/1", mem_addr, fetch_count);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, instr_valid, halted} !== 3'b000 || mem_addr !== 32'h0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0 || fetch_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b val=%b hlt=%b addr=%h ins=%h ipc=%h cnt=%h expected all zero",
               mem_req, instr_valid, halted, mem_addr, instruction, instr_pc, fetch_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_pc    = 32'h0;
    exp_count = 16'h0;
    mem_ready = 1'b1;
    tick();
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_fetch: got req=%b addr=%h expected 1/00000000", mem_req, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b1 || instruction !== 32'h13 || instr_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_instr: got val=%b ins=%h ipc=%h expected 1/00000013/00000000",
               instr_valid, instruction, instr_pc);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_pc       = 32'h0;
    exp_count    = 16'h0;
    rst          = 1'b1;
    clear_inputs();
    test_reset();
    test_straight_line();
    test_wait_backpressure();
    test_decode();
    test_redirect();
    test_halt_resume();
    test_pc_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
# fetch_controller

Multi-cycle instruction-fetch sequencer for the simple CPU. Owns the program counter and drives the instruction memory address. Latches the returned word into the instruction register and presents it, with decoded fields, to the execute stage over a valid/ready handshake. Supports branch redirect and halt, and replaces the free-running program_counter/instruction_register pairing with a controlled fetch loop.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, PC increment per accepted instruction (byte-addressed, 32-bit words)
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address; equals current PC
- mem_ready  in  1  memory has mem_rdata valid for mem_addr this cycle
- mem_rdata  in  32  instruction word from memory
- instr_valid  out  1  instruction/decoded fields valid for execute stage
- instr_ready  in  1  execute stage accepts the instruction this cycle
- instruction  out  32  latched instruction register
- instr_pc  out  32  PC the latched instruction was fetched from
- opcode/rd/rs1/rs2/func3/func7  out  7/5/5/5/3/7  combinational slices of instruction: [6:0], [11:7], [19:15], [24:20], [14:12], [31:25]
- redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc
- redirect_pc  in  32  target address; bits [1:0] ignored (treated as 0)
- halt  in  1  stop fetching after the current instruction is accepted
- halted  out  1  controller is in HALTED
- fetch_count  out  16  number of instructions accepted (instr_valid && instr_ready), wraps at 16'hFFFF -> 0

## Operation

- States: IDLE, FETCH, VALID, HALTED.
- IDLE: entered only from reset; outputs idle. Next cycle -> FETCH, or -> HALTED if halt=1.
- FETCH: mem_req=1, mem_addr=pc, both held stable until mem_ready. On mem_ready: instruction<=mem_rdata, instr_pc<=pc, -> VALID.
- VALID: instr_valid=1; instruction, instr_pc and fields held stable while instr_ready=0.
  - On instr_ready: fetch_count++, pc<=pc+PC_STEP (modulo 2^32).
  - Then -> HALTED if halt=1, else -> FETCH.
- HALTED: mem_req=0, instr_valid=0, halted=1. Stays until reset or redirect_valid.
- Redirect (highest priority, every state):
  - pc<=redirect_pc & ~32'h3, next state FETCH.
  - In FETCH: any coincident mem_ready data is discarded and instruction is not updated.
  - In VALID: the pending instruction is dropped; no count increment even if instr_ready=1.
  - In HALTED: resumes fetching and clears halted.
- Simultaneous redirect_valid and halt: redirect wins, halt ignored that cycle.
- Reset mid-operation: any outstanding request is abandoned without waiting for mem_ready.

## Timing

- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, halted=0, fetch_count=0.
- All outputs are registered or decoded from state/registers. No combinational path from mem_ready/instr_ready to mem_req/instr_valid.
- Reset deassert at edge 0 -> IDLE for cycle 0, FETCH (mem_req=1) in cycle 1.
- Zero-wait memory (mem_ready=1 in the FETCH cycle) -> instr_valid=1 in the next cycle.
- Each extra wait cycle adds one cycle of latency.
- Throughput with mem_ready=instr_ready=1 constantly: one instruction per 2 cycles.
- Redirect asserted in cycle N -> FETCH of redirect target in cycle N+1.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.

## Test plan

- Straight-line fetch: reset, mem_ready=instr_ready=1, memory words 0x00000013 onward. Expected instr_pc sequence 0,4,8,12 with instr_valid every other cycle, and fetch_count=4 after 8 cycles in the loop.
- Wait states and backpressure: mem_ready low for 3 cycles, then instr_ready low for 2 cycles. Expected: mem_addr and mem_req held through the wait, instruction/instr_pc stable through the stall, PC advances exactly once.
- Decode: mem_rdata=32'h40B50533 (sub x10,x10,x11). Expected opcode=7'b0110011, rd=10, rs1=10, rs2=11, func3=0, func7=7'b0100000.
- Redirect: redirect_valid with redirect_pc=32'h103, coincident with mem_ready in FETCH. Expected: data discarded, next mem_addr=32'h100, fetch_count unchanged. Repeat in VALID with instr_ready=1: no increment.
- Halt/resume: halt=1 during an accepted VALID handshake. Expected HALTED, halted=1, mem_req=0 for 10 cycles. redirect_valid with 32'h40 -> FETCH at 32'h40, halted=0.
- Async reset mid-FETCH with mem_ready=0: outputs return to reset values before the next clock edge, then a fresh fetch starts at RESET_PC.
